// File: rtl/pwm_regs_pkg.sv
// Address map constants and sizing helpers shared by the PWM register file.
package pwm_regs_pkg;

  localparam int unsigned CH_BASE   = 'h10;
  localparam int unsigned CH_STRIDE = 'h10;
  localparam int unsigned CH_SHIFT  = $clog2(CH_STRIDE);

  // Global region offsets
  localparam logic [3:0] OFF_PERIOD   = 4'h0;
  localparam logic [3:0] OFF_CNT_EN   = 4'h4;
  localparam logic [3:0] OFF_CNT_RST  = 4'h5;
  localparam logic [3:0] OFF_UPDN     = 4'h6;
  localparam logic [3:0] OFF_PRESCALE = 4'h7;
  localparam logic [3:0] OFF_CNT_VAL  = 4'h8;
  localparam logic [3:0] OFF_STATUS   = 4'hC;
  localparam logic [3:0] OFF_IRQ_EN   = 4'hD;
  localparam logic [3:0] OFF_SHADOW   = 4'hE;

  // Per-channel offsets
  localparam logic [3:0] OFF_CMP1     = 4'h0;
  localparam logic [3:0] OFF_CMP2     = 4'h4;
  localparam logic [3:0] OFF_PWM_EN   = 4'h8;
  localparam logic [3:0] OFF_FUNC     = 4'h9;

  // Number of byte lanes backing a CNT_W-wide register
  function automatic int unsigned byte_lanes(input int unsigned cnt_w);
    return cnt_w / 8;
  endfunction

endpackage

// File: rtl/pwm_regs_ch.sv
// One PWM channel: staged/active compare registers, enable and mode.
module pwm_regs_ch
  import pwm_regs_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [3:0]       off,
  input  logic [7:0]       data_write,
  input  logic             load,
  output logic [CNT_W-1:0] compare1,
  output logic [CNT_W-1:0] compare2,
  output logic             pwm_en,
  output logic [1:0]       functions,
  output logic [7:0]       rdata_c
);

  localparam int unsigned LANES = byte_lanes(CNT_W);

  logic [CNT_W-1:0] cmp1_stg;
  logic [CNT_W-1:0] cmp2_stg;

  // Byte writes into staging and the unstaged control fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp1_stg  <= '0;
      cmp2_stg  <= '0;
      pwm_en    <= 1'b0;
      functions <= 2'b00;
    end else if (wr) begin
      for (int unsigned n = 0; n < LANES; n++) begin
        if (off == OFF_CMP1 + 4'(n)) cmp1_stg[8*n +: 8] <= data_write;
        if (off == OFF_CMP2 + 4'(n)) cmp2_stg[8*n +: 8] <= data_write;
      end
      if (off == OFF_PWM_EN) pwm_en    <= data_write[0];
      if (off == OFF_FUNC)   functions <= data_write[1:0];
    end
  end

  // Active compares take the whole staged word at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      compare1 <= '0;
      compare2 <= '0;
    end else if (load) begin
      compare1 <= cmp1_stg;
      compare2 <= cmp2_stg;
    end
  end

  // Readback mux; staging (not active) values are visible
  always_comb begin
    rdata_c = 8'h00;
    if (off[3:2] == OFF_CMP1[3:2]) begin
      if (32'(off[1:0]) < LANES) rdata_c = 8'(cmp1_stg >> {off[1:0], 3'b000});
    end else if (off[3:2] == OFF_CMP2[3:2]) begin
      if (32'(off[1:0]) < LANES) rdata_c = 8'(cmp2_stg >> {off[1:0], 3'b000});
    end else if (off == OFF_PWM_EN) begin
      rdata_c = {7'b0, pwm_en};
    end else if (off == OFF_FUNC) begin
      rdata_c = {6'b0, functions};
    end
  end

endmodule

// File: rtl/pwm_regs_mc.sv
// Multi-channel PWM register file: global counter controls, shadowed
// period/compares, counter-reset pulse, COUNTER_VAL snapshot, match status.
module pwm_regs_mc
  import pwm_regs_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned RST_PULSE_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [7:0]              data_write,
  output logic [7:0]              data_read,
  input  logic [CNT_W-1:0]        counter_val,
  input  logic                    period_end,
  input  logic [NUM_CH-1:0]       ch_match,
  output logic [CNT_W-1:0]        period,
  output logic                    en,
  output logic                    count_reset,
  output logic                    upnotdown,
  output logic [7:0]              prescale,
  output logic [NUM_CH-1:0]       pwm_en,
  output logic [2*NUM_CH-1:0]     functions,
  output logic [NUM_CH*CNT_W-1:0] compare1,
  output logic [NUM_CH*CNT_W-1:0] compare2,
  output logic                    irq
);

  localparam int unsigned LANES       = byte_lanes(CNT_W);
  localparam int unsigned BLK_W       = ADDR_W - CH_SHIFT;
  localparam int unsigned CH_BASE_BLK = CH_BASE / CH_STRIDE;
  localparam int unsigned SNAP_W      = (CNT_W > 8) ? CNT_W - 8 : 1;
  localparam int unsigned RC_W        = 4;

  logic [BLK_W-1:0]  blk;
  logic [3:0]        off;
  logic              glb_sel;
  logic              wr_glb;
  logic              rst_wr;
  logic              cv_rd;
  logic              load;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] ch_sel;
  logic [7:0]        ch_rdata [NUM_CH];

  logic [CNT_W-1:0]  period_stg;
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] irq_en;
  logic              shadow_ctrl;
  logic [SNAP_W-1:0] snap;
  logic [RC_W-1:0]   rst_cnt;

  assign blk     = addr[ADDR_W-1:CH_SHIFT];
  assign off     = addr[CH_SHIFT-1:0];
  assign glb_sel = (blk == '0);
  assign wr_glb  = write && glb_sel;
  assign rst_wr  = wr_glb && (off == OFF_CNT_RST);
  assign cv_rd   = read && glb_sel && (off == OFF_CNT_VAL);
  assign clr     = (wr_glb && (off == OFF_STATUS)) ? data_write[NUM_CH-1:0] : '0;
  // Shadowed: load at period boundary; immediate: every cycle; counter reset forces a load
  assign load    = rst_wr || !shadow_ctrl || period_end;
  assign irq     = |(status & irq_en);

  // Global control registers and period staging
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_stg  <= '0;
      en          <= 1'b0;
      upnotdown   <= 1'b0;
      prescale    <= 8'h00;
      irq_en      <= '0;
      shadow_ctrl <= 1'b1;
    end else if (wr_glb) begin
      for (int unsigned n = 0; n < LANES; n++) begin
        if (off == OFF_PERIOD + 4'(n)) period_stg[8*n +: 8] <= data_write;
      end
      case (off)
        OFF_CNT_EN:   en          <= data_write[0];
        OFF_UPDN:     upnotdown   <= data_write[0];
        OFF_PRESCALE: prescale    <= data_write;
        OFF_IRQ_EN:   irq_en      <= data_write[NUM_CH-1:0];
        OFF_SHADOW:   shadow_ctrl <= data_write[0];
        default: ;
      endcase
    end
  end

  // Active period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    period <= '0;
    else if (load) period <= period_stg;
  end

  // Sticky match status; a set wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status <= '0;
    else        status <= (status & ~clr) | ch_match;
  end

  // Upper COUNTER_VAL bytes frozen when the low byte is read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     snap <= '0;
    else if (cv_rd) snap <= SNAP_W'(counter_val >> 8);
  end

  // Self-timed count_reset pulse; a rewrite restarts the full length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reset <= 1'b0;
      rst_cnt     <= '0;
    end else if (rst_wr) begin
      count_reset <= 1'b1;
      rst_cnt     <= RC_W'(RST_PULSE_CYC - 1);
    end else if (rst_cnt != '0) begin
      rst_cnt     <= rst_cnt - RC_W'(1);
    end else begin
      count_reset <= 1'b0;
    end
  end

  // Channel instances with block-address select
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_sel[c] = (blk == BLK_W'(CH_BASE_BLK + c));

    pwm_regs_ch #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr         (write && ch_sel[c]),
      .off        (off),
      .data_write (data_write),
      .load       (load),
      .compare1   (compare1[c*CNT_W +: CNT_W]),
      .compare2   (compare2[c*CNT_W +: CNT_W]),
      .pwm_en     (pwm_en[c]),
      .functions  (functions[2*c +: 2]),
      .rdata_c    (ch_rdata[c])
    );
  end

  // Combinational read mux; zero when not reading
  always_comb begin
    data_read = 8'h00;
    if (read) begin
      if (glb_sel) begin
        if (off[3:2] == OFF_PERIOD[3:2]) begin
          if (32'(off[1:0]) < LANES) data_read = 8'(period_stg >> {off[1:0], 3'b000});
        end else if (off[3:2] == OFF_CNT_VAL[3:2]) begin
          if (off[1:0] == 2'b00)          data_read = counter_val[7:0];
          else if (32'(off[1:0]) < LANES) data_read = 8'({snap, 8'h00} >> {off[1:0], 3'b000});
        end else begin
          case (off)
            OFF_CNT_EN:   data_read = {7'b0, en};
            OFF_UPDN:     data_read = {7'b0, upnotdown};
            OFF_PRESCALE: data_read = prescale;
            OFF_STATUS:   data_read = 8'(status);
            OFF_IRQ_EN:   data_read = 8'(irq_en);
            OFF_SHADOW:   data_read = {7'b0, shadow_ctrl};
            default:      data_read = 8'h00;
          endcase
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel[c]) data_read = ch_rdata[c];
      end
    end
  end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// Scoreboard bench for pwm_regs_mc at default parameters.
module tb_pwm_regs_mc;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 8;

  logic                    clk;
  logic                    rst_n;
  logic                    read;
  logic                    write;
  logic [ADDR_W-1:0]       addr;
  logic [7:0]              data_write;
  logic [7:0]              data_read;
  logic [CNT_W-1:0]        counter_val;
  logic                    period_end;
  logic [NUM_CH-1:0]       ch_match;
  logic [CNT_W-1:0]        period;
  logic                    en;
  logic                    count_reset;
  logic                    upnotdown;
  logic [7:0]              prescale;
  logic [NUM_CH-1:0]       pwm_en;
  logic [2*NUM_CH-1:0]     functions;
  logic [NUM_CH*CNT_W-1:0] compare1;
  logic [NUM_CH*CNT_W-1:0] compare2;
  logic                    irq;

  logic [63:0] sb[$];
  int n_cmp;
  int n_err;
  int hi;

  pwm_regs_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .RST_PULSE_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read), .counter_val(counter_val),
    .period_end(period_end), .ch_match(ch_match), .period(period), .en(en),
    .count_reset(count_reset), .upnotdown(upnotdown), .prescale(prescale),
    .pwm_en(pwm_en), .functions(functions), .compare1(compare1),
    .compare2(compare2), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected value goes through the scoreboard before the observation
  task automatic expect_out(input string tag, input logic [63:0] got, input logic [63:0] exp);
    sb.push_back(exp);
    chk(tag, got, sb.pop_front());
  endtask

  // One bus cycle: drive at negedge, optionally check read data, release after posedge
  task automatic cyc(input logic rd_en, input logic wr_en, input logic [7:0] a,
                     input logic [7:0] d, input logic pe, input logic [NUM_CH-1:0] m,
                     input logic chk_rd, input logic [7:0] exp_rd, input string tag);
    @(negedge clk);
    read = rd_en; write = wr_en; addr = a; data_write = d; period_end = pe; ch_match = m;
    if (chk_rd) sb.push_back({56'b0, exp_rd});
    #1;
    if (chk_rd) chk(tag, {56'b0, data_read}, sb.pop_front());
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0; period_end = 1'b0; ch_match = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0, '0, 1'b0, 8'h00, "");
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    cyc(1'b1, 1'b0, a, 8'h00, 1'b0, '0, 1'b1, exp, tag);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, '0, 1'b0, 8'h00, "");
  endtask

  task automatic pe_pulse();
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, '0, 1'b0, 8'h00, "");
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; read = 1'b0; write = 1'b0; addr = '0; data_write = '0;
    counter_val = '0; period_end = 1'b0; ch_match = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Reset state
    expect_out("rst_period", 64'(period), 64'h0);
    expect_out("rst_ctrl", 64'({en, count_reset, upnotdown}), 64'h0);
    expect_out("rst_prescale", 64'(prescale), 64'h0);
    expect_out("rst_pwm_en", 64'(pwm_en), 64'h0);
    expect_out("rst_functions", 64'(functions), 64'h0);
    expect_out("rst_compare1", compare1, 64'h0);
    expect_out("rst_compare2", compare2, 64'h0);
    expect_out("rst_irq", 64'(irq), 64'h0);
    for (int a = 0; a < 15; a++) rd(8'(a), (a == 14) ? 8'h01 : 8'h00, "rst_glb_rd");
    for (int c = 0; c < 4; c++)
      for (int o = 0; o < 10; o++) rd(8'(16 * (c + 1) + o), 8'h00, "rst_ch_rd");

    // Shadowed period update
    wr(8'h00, 8'h34);
    wr(8'h01, 8'h12);
    expect_out("shadow_hold", 64'(period), 64'h0);
    rd(8'h00, 8'h34, "stg_rd_b0");
    rd(8'h01, 8'h12, "stg_rd_b1");
    pe_pulse();
    expect_out("shadow_load", 64'(period), 64'h1234);
    cyc(1'b0, 1'b1, 8'h01, 8'h56, 1'b1, '0, 1'b0, 8'h00, "");
    expect_out("coincident_old", 64'(period), 64'h1234);
    rd(8'h01, 8'h56, "coincident_stg");
    pe_pulse();
    expect_out("coincident_new", 64'(period), 64'h5634);
    wr(8'h00, 8'h78);
    expect_out("stg_no_load", 64'(period), 64'h5634);

    // Counter reset pulse, forced load, restart, async drop
    expect_out("cr_idle", 64'(count_reset), 64'h0);
    wr(8'h05, 8'h00);
    expect_out("cr_first", 64'(count_reset), 64'h1);
    expect_out("cr_forced_load", 64'(period), 64'h5678);
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (count_reset) hi++;
    end
    expect_out("cr_len", 64'(hi), 64'd4);
    rd(8'h05, 8'h00, "cr_reads0");
    wr(8'h05, 8'h00);
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, (i == 2), 8'h05, 8'h00, 1'b0, '0, 1'b0, 8'h00, "");
      if (count_reset) hi++;
    end
    expect_out("cr_restart_len", 64'(hi), 64'd7);
    wr(8'h05, 8'h00);
    idle();
    @(negedge clk) rst_n = 1'b0;
    #1;
    expect_out("cr_async_drop", 64'(count_reset), 64'h0);
    expect_out("async_period", 64'(period), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    rd(8'h0E, 8'h01, "shadow_after_rst");

    // COUNTER_VAL snapshot
    counter_val = 16'hABCD;
    rd(8'h08, 8'hCD, "cv_live_lo");
    counter_val = 16'h1111;
    rd(8'h09, 8'hAB, "cv_snap_hi");
    rd(8'h0A, 8'h00, "cv_lane2");
    rd(8'h08, 8'h11, "cv_live_lo2");

    // Read with simultaneous write returns pre-write value
    cyc(1'b1, 1'b1, 8'h07, 8'h55, 1'b0, '0, 1'b1, 8'h00, "rw_pre");
    expect_out("rw_post", 64'(prescale), 64'h55);
    wr(8'h04, 8'hFF);
    wr(8'h06, 8'h01);
    expect_out("en_updn", 64'({en, upnotdown}), 64'h3);
    rd(8'h04, 8'h01, "en_rd");

    // Immediate mode channel compare and ignored addresses
    wr(8'h0E, 8'h00);
    wr(8'h30, 8'hFF);
    wr(8'h31, 8'h00);
    expect_out("ch2_cmp1", compare1, 64'h0000_00FF_0000_0000);
    wr(8'h31, 8'hA5);
    expect_out("ch2_cmp1_lat", compare1, 64'h0000_00FF_0000_0000);
    idle();
    expect_out("ch2_cmp1_upd", compare1, 64'h0000_A5FF_0000_0000);
    expect_out("cmp2_clean", compare2, 64'h0);
    wr(8'h50, 8'h77);
    wr(8'h32, 8'h99);
    rd(8'h50, 8'h00, "ch4_ignored");
    rd(8'h32, 8'h00, "lane2_ignored");
    rd(8'h3A, 8'h00, "reserved_off");
    wr(8'h28, 8'h01);
    wr(8'h29, 8'hFF);
    expect_out("ch1_pwm_en", 64'(pwm_en), 64'h2);
    expect_out("ch1_func", 64'(functions), 64'h0C);
    rd(8'h29, 8'h03, "ch1_func_rd");

    // Status / irq
    wr(8'h0D, 8'h04);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'b0100, 1'b0, 8'h00, "");
    rd(8'h0C, 8'h04, "st_set");
    expect_out("irq_set", 64'(irq), 64'h1);
    cyc(1'b0, 1'b1, 8'h0C, 8'h04, 1'b0, 4'b0100, 1'b0, 8'h00, "");
    rd(8'h0C, 8'h04, "st_set_wins");
    wr(8'h0C, 8'h04);
    rd(8'h0C, 8'h00, "st_clr");
    expect_out("irq_clr", 64'(irq), 64'h0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'b0010, 1'b0, 8'h00, "");
    expect_out("irq_masked", 64'(irq), 64'h0);
    wr(8'h0C, 8'h00);
    rd(8'h0C, 8'h02, "st_w0_noop");
    rd(8'h0D, 8'h04, "irq_en_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
